gol_gen_ctrl: RTL and testbench

GOL_GEN_CTRL -- requirements
Module: gol_gen_ctrl

---
 rtl/gol_gen_ctrl.sv | 141 ++++++++++++++
 tb/tb_gol_gen_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gol_gen_ctrl.sv
// Game-of-Life generation sequencer: scans the row register file once per generation,
// writing each row's new value one cycle late so its old value still feeds the row below.
module gol_gen_ctrl #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int GENBITS = 16
) (
    input  logic               ph2,
    input  logic               reset,
    input  logic               start,
    input  logic               run,
    input  logic [7:0]         period,
    input  logic               load_req,
    input  logic [REGBITS-1:0] load_addr,
    input  logic [WIDTH-1:0]   load_data,
    output logic               load_ack,
    input  logic [WIDTH-1:0]   nextrow,
    output logic [REGBITS-1:0] ra,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic               regwrite,
    output logic               busy,
    output logic               gen_done,
    output logic [GENBITS-1:0] gen_count,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [REGBITS-1:0] LAST_ROW = {REGBITS{1'b1}};

    state_t               state_q, state_d;
    logic [REGBITS-1:0]   r_q, r_d;
    logic [WIDTH-1:0]     pend_q, pend_d;
    logic [GENBITS-1:0]   gen_q, gen_d;
    logic [7:0]           wcnt_q, wcnt_d;

    logic [REGBITS-1:0]   ra_c, wa_c;
    logic [WIDTH-1:0]     wd_c;
    logic                 we_c, ack_c, done_c;

    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            pend_q  <= '0;
            gen_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            pend_q  <= pend_d;
            gen_q   <= gen_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        pend_d  = pend_q;
        gen_d   = gen_q;
        wcnt_d  = wcnt_q;
        ra_c    = '0;
        wa_c    = '0;
        wd_c    = '0;
        we_c    = 1'b0;
        ack_c   = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                r_d = '0;
                if (load_req) begin
                    wa_c  = load_addr;
                    wd_c  = load_data;
                    we_c  = 1'b1;
                    ack_c = 1'b1;
                end else if (start || run) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                ra_c   = r_q;
                pend_d = nextrow;
                // Row r-1 is written only now, after row r's new value used its old contents.
                if (r_q != '0) begin
                    wa_c = r_q - 1'b1;
                    wd_c = pend_q;
                    we_c = 1'b1;
                end
                if (r_q == LAST_ROW) begin
                    state_d = S_FLUSH;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_FLUSH: begin
                wa_c    = LAST_ROW;
                wd_c    = pend_q;
                we_c    = 1'b1;
                r_d     = '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                gen_d   = gen_q + 1'b1;
                wcnt_d  = '0;
                state_d = run ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (wcnt_q >= period) begin
                    r_d     = '0;
                    state_d = S_SCAN;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even if the host keeps load_req up.
    assign ra          = reset ? ra_c : '0;
    assign wa          = reset ? wa_c : '0;
    assign wd          = reset ? wd_c : '0;
    assign regwrite    = reset & we_c;
    assign load_ack    = reset & ack_c;
    assign gen_done    = reset & done_c;
    assign busy        = reset & ((state_q == S_SCAN) || (state_q == S_FLUSH) || (state_q == S_DONE));
    assign gen_count   = gen_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gol_gen_ctrl.sv
// Directed bench for gol_gen_ctrl; nextrow is supplied as ra*3 so written values are predictable.
module tb_gol_gen_ctrl;

    localparam int W  = 8;
    localparam int RB = 3;
    localparam int GB = 4;

    logic          ph2, reset, start, run, load_req, load_ack;
    logic [7:0]    period;
    logic [RB-1:0] load_addr, ra, wa;
    logic [W-1:0]  load_data, nextrow, wd;
    logic          regwrite, busy, gen_done;
    logic [GB-1:0] gen_count;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic          sb_on = 1'b0;
    logic [RB+W-1:0] exp_q[$];

    gol_gen_ctrl #(.WIDTH(W), .REGBITS(RB), .GENBITS(GB)) dut (
        .ph2(ph2), .reset(reset), .start(start), .run(run), .period(period),
        .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
        .load_ack(load_ack), .nextrow(nextrow), .ra(ra), .wa(wa), .wd(wd),
        .regwrite(regwrite), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count), .dbg_state_o(dbg_state)
    );

    // clock / reset block
    initial begin
        ph2 = 1'b0;
        forever #5 ph2 = ~ph2;
    end

    always_comb nextrow = {5'b0, ra} * 8'd3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge ph2);
        #2;
    endtask

    // scoreboard: every register-file write while enabled must match the queue head
    always @(negedge ph2) begin
        if (sb_on && regwrite) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_write", {21'b0, wa, wd}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_write", {21'b0, wa, wd}, {21'b0, exp_q.pop_front()});
            end
        end
    end

    logic [7:0] load_tbl [8];
    int ndone, last, exp_gen;

    initial begin
        load_tbl = '{8'h18, 8'h30, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        reset = 1'b1; start = 1'b1; run = 1'b1; period = 8'd0;
        load_req = 1'b1; load_addr = 3'd3; load_data = 8'hFF;
        #1 reset = 1'b0;
        step();
        // all outputs low during reset despite active requests
        chk("rst_regwrite", regwrite, 0);
        chk("rst_load_ack", load_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wa_wd", {wa, wd}, 0);
        chk("rst_ra", ra, 0);
        chk("rst_gen_done", gen_done, 0);
        chk("rst_gen_count", gen_count, 0);
        load_req = 1'b0; start = 1'b0; run = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("idle_state", dbg_state, 0);

        // host row loads
        for (int i = 0; i < 8; i++) begin
            load_req = 1'b1; load_addr = RB'(i); load_data = load_tbl[i];
            #1;
            chk("load_ack", load_ack, 1);
            chk("load_regwrite", regwrite, 1);
            chk("load_wa", wa, i);
            chk("load_wd", wd, load_tbl[i]);
            chk("load_busy", busy, 0);
            step();
        end
        load_req = 1'b0;
        #1;
        chk("load_ack_off", load_ack, 0);
        chk("load_we_off", regwrite, 0);

        // single generation: writes on cycles 2..9, gen_done on 10
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk("gen_done_cyc", gen_done, (c == 10));
            chk("busy_cyc", busy, 1);
            chk("regwrite_cyc", regwrite, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) begin
                chk("wa_cyc", wa, (c <= 8) ? c - 2 : 7);
                chk("wd_cyc", wd, ((c <= 8) ? c - 2 : 7) * 3);
            end
            if (c <= 8) chk("ra_cyc", ra, c - 1);
            step();
        end
        #1;
        chk("after_gen_busy", busy, 0);
        chk("after_gen_count", gen_count, 1);

        // load and start together: load wins, start taken next cycle
        load_req = 1'b1; load_addr = 3'd3; load_data = 8'hAA; start = 1'b1;
        #1;
        chk("ls_ack", load_ack, 1);
        chk("ls_wa_wd", {wa, wd}, {3'd3, 8'hAA});
        step();
        load_req = 1'b0;
        #1;
        chk("ls_still_idle", busy, 0);
        step();
        start = 1'b0; load_req = 1'b1; load_addr = 3'd5; load_data = 8'h55;
        for (int c = 0; c <= 9; c++) begin
            #1;
            chk("busy_no_ack", load_ack, 0);
            chk("busy_hi", busy, 1);
            chk("busy_gen_done", gen_done, (c == 9));
            step();
        end
        #1;
        chk("held_load_ack", load_ack, 1);
        chk("held_load_wd", {wa, wd}, {3'd5, 8'h55});
        chk("gen_count_2", gen_count, 2);
        step();
        load_req = 1'b0;

        // continuous mode, period 3: three generations, then stop in WAIT
        period = 8'd3;
        for (int g = 0; g < 3; g++)
            for (int r = 0; r < 8; r++) exp_q.push_back({RB'(r), W'(r * 3)});
        sb_on = 1'b1;
        for (int cyc = 0; cyc < 56; cyc++) begin
            if (cyc == 0) run = 1'b1;
            if (cyc == 40) run = 1'b0;
            #1;
            chk("run_gen_done", gen_done, (cyc == 10 || cyc == 24 || cyc == 38));
            chk("run_busy", busy, ((cyc >= 1 && cyc <= 10) || (cyc >= 15 && cyc <= 24) ||
                                   (cyc >= 29 && cyc <= 38)));
            if (cyc == 41) chk("run_stop_idle", dbg_state, 0);
            step();
        end
        sb_on = 1'b0;
        chk("sb_drained", exp_q.size(), 0);
        chk("gen_count_5", gen_count, 5);

        // reset in the middle of SCAN at row 4
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #1;
        chk("mid_ra", ra, 4);
        chk("mid_write", {regwrite, wa, wd}, {1'b1, 3'd3, 8'd9});
        reset = 1'b0;
        #1;
        chk("abort_regwrite", regwrite, 0);
        chk("abort_busy", busy, 0);
        chk("abort_state", dbg_state, 0);
        chk("abort_gen_count", gen_count, 0);
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("post_abort_quiet", {gen_done, busy, regwrite}, 0);
            step();
        end

        // counter wrap: period 0 gives one WAIT cycle, 11 cycles per generation
        period = 8'd0; run = 1'b1;
        ndone = 0; last = 0; exp_gen = 0;
        for (int cyc = 0; cyc < 400 && ndone < 16; cyc++) begin
            #1;
            if (gen_done) begin
                chk("wrap_count", gen_count, exp_gen);
                chk("wrap_spacing", cyc - last, (ndone == 0) ? 10 : 11);
                last = cyc;
                exp_gen = (exp_gen + 1) % 16;
                ndone++;
                if (ndone == 16) run = 1'b0;
            end
            step();
        end
        chk("wrap_all_done", ndone, 16);
        #1;
        chk("wrap_to_zero", gen_count, 0);
        chk("wrap_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
